axi_isolate_ctrl: RTL
=====================

// Module: axi_isolate_ctrl
// PURPOSE
//  Sequences the isolate input of the AXI dual-clock slave slice for power/clock gating. Tracks outstanding
//  write/read transactions on the slave-side AXI bus and, on request, blocks new AW/AR handshakes.
//  Waits for the bus to drain, then asserts isolate and acknowledges. Sits between the SoC power
//  controller and the slice wrapper, in the slave-side clock domain.
// PARAMETERS
//  MAX_OUTSTANDING  16    max in-flight bursts per direction; new AW/AR blocked at limit
//  TIMEOUT_CYCLES   1024  drain timeout (used only with AXI_ISOLATE_TIMEOUT_EN)
// PORTS
//  clk_i          in   1   slave-side clock
//  rst_i          in   1   asynchronous reset, active-high
//  isolate_req_i  in   1   level request: 1 = isolate, 0 = run
//  isolate_o      out  1   drives the slice isolate input
//  isolate_ack_o  out  1   1 while in ISOLATED
//  timeout_o      out  1   drain ended by timeout (sticky until RUN)
//  aw_valid_i / aw_ready_i  in  1/1  master AW valid / slice AW ready
//  aw_valid_o / aw_ready_o  out 1/1  gated AW valid to slice / gated AW ready to master
//  ar_valid_i / ar_ready_i / ar_valid_o / ar_ready_o  as AW, for AR
//  w_valid_i, w_ready_i, w_last_i    in  1 each  W channel monitor (not gated)
//  b_valid_i, b_ready_i              in  1 each  B channel monitor
//  r_valid_i, r_ready_i, r_last_i    in  1 each  R channel monitor
// BEHAVIOUR
//  - Reset: state RUN, counters 0, w_busy 0, isolate_o=0, isolate_ack_o=0, timeout_o=0.
//  - Gating (combinational): aw_open = (state==RUN) && (wr_cnt < MAX_OUTSTANDING);
//    aw_valid_o = aw_valid_i & aw_open; aw_ready_o = aw_ready_i & aw_open. AR likewise with rd_cnt.
//  - wr_cnt: +1 on aw_valid_o&aw_ready_i, -1 on b_valid_i&b_ready_i; both in same cycle -> unchanged.
//  - rd_cnt: +1 on ar_valid_o&ar_ready_i, -1 on r_valid_i&r_ready_i&r_last_i; same rule.
//  - w_busy: set on W beat accepted with w_last_i=0, cleared on beat accepted with w_last_i=1.
//  - Decrement at 0 never wraps (protocol violation; counter holds 0).
//  - FSM:
//     RUN      -> DRAIN     when isolate_req_i=1 (gating closes in the next cycle; a handshake in the
//                           transition cycle is counted normally)
//     DRAIN    -> ISOLATED  when wr_cnt==0 && rd_cnt==0 && !w_busy (registered; 1-cycle check latency)
//     DRAIN    -> RUN       when isolate_req_i=0 (abort, no isolate pulse)
//     ISOLATED -> RUN       when isolate_req_i=0
//  - isolate_o, isolate_ack_o registered: 1 exactly while state==ISOLATED. Min req->ack latency
//    with an idle bus: 2 cycles.
//  - ISOLATED: counters held (no handshakes visible since the slice blocks them); w_busy held.
//  - Reset mid-drain: immediate return to RUN, isolate_o=0 asynchronously.
// CONFIGURATION
//  AXI_ISOLATE_TIMEOUT_EN defined: a cycle counter runs in DRAIN. When it reaches TIMEOUT_CYCLES-1,
//   the FSM goes DRAIN->ISOLATED, wr_cnt/rd_cnt/w_busy are cleared, and timeout_o=1 until the
//   next entry to RUN. The counter is cleared on every DRAIN entry.
//  Not defined: no timer; DRAIN waits indefinitely; timeout_o tied 0.
// STRUCTURE
//  axi_isolate_pkg: state enum {RUN, DRAIN, ISOLATED}; cnt_width(MAX_OUTSTANDING)=$clog2(MAX+1).
//  Sub-module axi_isolate_cnt: saturating up/down counter with inc, dec, clr, at_max and is_zero outputs.
//   Instantiated twice (wr, rd).
// TESTING
//  1 Idle bus, isolate_req_i 0->1 at cycle 0 -> isolate_o=isolate_ack_o=1 at cycle 2; aw/ar_ready_o=0 from cycle 1.
//  2 3 AW accepted, req=1, then 3 B handshakes at cycles 10,11,12 -> ack asserted at cycle 14, not before.
//  3 AR len=4 in flight, req=1 -> ack only after R beat with r_last=1; new ar_valid_i held 1 gets ar_valid_o=0.
//  4 MAX_OUTSTANDING=2: 2 AW accepted, no B -> 3rd AW blocked (aw_ready_o=0) in RUN; B returns -> 3rd accepted.
//  5 AW handshake and B handshake in same cycle with wr_cnt=1 -> wr_cnt stays 1; req drop in DRAIN -> RUN, isolate_o never 1.
//  6 TIMEOUT_EN, TIMEOUT_CYCLES=8, B withheld -> ISOLATED 8 cycles after DRAIN entry, timeout_o=1; req=0 -> RUN, timeout_o=0.

Source files
------------

// File: rtl/axi_isolate_pkg.sv
// Shared types and helpers for the AXI isolate controller.
//   iso_state_t : controller states RUN / DRAIN / ISOLATED
//   cnt_width() : bit width needed to hold 0..max_outstanding
package axi_isolate_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        DRAIN    = 2'd1,
        ISOLATED = 2'd2
    } iso_state_t;

    function automatic int unsigned cnt_width(input int unsigned max_outstanding);
        return $clog2(max_outstanding + 1);
    endfunction

endpackage

// File: rtl/axi_isolate_cnt.sv
// Saturating up/down outstanding-burst counter.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   inc, dec  : count up / down; both together leave the count unchanged
//   clr       : synchronous clear (wins over inc/dec)
//   at_max    : count has reached MAX
//   is_zero   : count is zero
module axi_isolate_cnt
    import axi_isolate_pkg::*;
#(
    parameter int unsigned MAX = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic dec,
    input  logic clr,
    output logic at_max,
    output logic is_zero
);

    localparam int unsigned W = cnt_width(MAX);

    logic [W-1:0] count;

    // A decrement at zero is a protocol violation upstream; holding at zero
    // keeps the drain check from being fooled by a wrapped count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && !dec && !at_max) begin
            count <= count + W'(1);
        end else if (dec && !inc && !is_zero) begin
            count <= count - W'(1);
        end
    end

    assign at_max  = (count >= W'(MAX));
    assign is_zero = (count == '0);

endmodule

// File: rtl/axi_isolate_ctrl.sv
// Isolate sequencer for the AXI dual-clock slave slice (slave-side clock domain).
// On isolate_req_i it closes the AW/AR handshakes, waits for outstanding
// writes/reads and any open W burst to finish, then asserts isolate_o and
// isolate_ack_o. Dropping the request returns to RUN (aborting a drain).
// Ports:
//   clk_i, rst_i                 : clock, asynchronous active-high reset
//   isolate_req_i                : level request, 1 = isolate
//   isolate_o, isolate_ack_o     : high exactly while ISOLATED
//   timeout_o                    : drain ended by timeout (sticky until RUN)
//   aw_/ar_ valid/ready _i/_o    : gated address handshakes master <-> slice
//   w_*, b_*, r_*                : monitored data/response channels
// Build option: define AXI_ISOLATE_TIMEOUT_EN to bound DRAIN to TIMEOUT_CYCLES;
// otherwise DRAIN waits indefinitely and timeout_o is tied low.
module axi_isolate_ctrl
    import axi_isolate_pkg::*;
#(
    parameter int unsigned MAX_OUTSTANDING = 16,
    parameter int unsigned TIMEOUT_CYCLES  = 1024
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic isolate_req_i,
    output logic isolate_o,
    output logic isolate_ack_o,
    output logic timeout_o,
    input  logic aw_valid_i,
    input  logic aw_ready_i,
    output logic aw_valid_o,
    output logic aw_ready_o,
    input  logic ar_valid_i,
    input  logic ar_ready_i,
    output logic ar_valid_o,
    output logic ar_ready_o,
    input  logic w_valid_i,
    input  logic w_ready_i,
    input  logic w_last_i,
    input  logic b_valid_i,
    input  logic b_ready_i,
    input  logic r_valid_i,
    input  logic r_ready_i,
    input  logic r_last_i
);

    if (MAX_OUTSTANDING < 1 || TIMEOUT_CYCLES < 2) begin : g_param_check
        $error("axi_isolate_ctrl: MAX_OUTSTANDING must be >= 1 and TIMEOUT_CYCLES >= 2");
    end

    iso_state_t state, state_nxt;

    logic aw_open, ar_open;
    logic wr_at_max, wr_zero, rd_at_max, rd_zero;
    logic wr_inc, wr_dec, rd_inc, rd_dec;
    logic hold, cnt_clr, drain_timeout, drained;
    logic w_busy;

    assign hold    = (state == ISOLATED);
    assign aw_open = (state == RUN) && !wr_at_max;
    assign ar_open = (state == RUN) && !rd_at_max;

    assign aw_valid_o = aw_valid_i & aw_open;
    assign aw_ready_o = aw_ready_i & aw_open;
    assign ar_valid_o = ar_valid_i & ar_open;
    assign ar_ready_o = ar_ready_i & ar_open;

    assign wr_inc = aw_valid_o & aw_ready_i;
    assign wr_dec = b_valid_i & b_ready_i & ~hold;
    assign rd_inc = ar_valid_o & ar_ready_i;
    assign rd_dec = r_valid_i & r_ready_i & r_last_i & ~hold;

    axi_isolate_cnt #(.MAX(MAX_OUTSTANDING)) u_wr_cnt (
        .clk     (clk_i),
        .rst     (rst_i),
        .inc     (wr_inc),
        .dec     (wr_dec),
        .clr     (cnt_clr),
        .at_max  (wr_at_max),
        .is_zero (wr_zero)
    );

    axi_isolate_cnt #(.MAX(MAX_OUTSTANDING)) u_rd_cnt (
        .clk     (clk_i),
        .rst     (rst_i),
        .inc     (rd_inc),
        .dec     (rd_dec),
        .clr     (cnt_clr),
        .at_max  (rd_at_max),
        .is_zero (rd_zero)
    );

    // Tracks a W burst that has started but not yet delivered its last beat.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            w_busy <= 1'b0;
        end else if (cnt_clr) begin
            w_busy <= 1'b0;
        end else if (!hold && w_valid_i && w_ready_i) begin
            w_busy <= !w_last_i;
        end
    end

    assign drained = wr_zero && rd_zero && !w_busy;

`ifdef AXI_ISOLATE_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES);

    logic [TW-1:0] tmr;
    logic          timeout_q;

    // Held at zero outside DRAIN, so every DRAIN entry starts from zero.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tmr <= '0;
        end else if (state != DRAIN) begin
            tmr <= '0;
        end else begin
            tmr <= tmr + TW'(1);
        end
    end

    assign drain_timeout = (state == DRAIN) && (tmr == TW'(TIMEOUT_CYCLES - 1));
    // A forced isolate abandons the bus bookkeeping; the slice is reset-equivalent afterwards.
    assign cnt_clr       = drain_timeout && isolate_req_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            timeout_q <= 1'b0;
        end else if (state_nxt == RUN) begin
            timeout_q <= 1'b0;
        end else if (cnt_clr) begin
            timeout_q <= 1'b1;
        end
    end

    assign timeout_o = timeout_q;
`else
    assign drain_timeout = 1'b0;
    assign cnt_clr       = 1'b0;
    assign timeout_o     = 1'b0;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // Abort (request dropped) takes priority over completing the drain.
    always_comb begin
        state_nxt = state;
        unique case (state)
            RUN: begin
                if (isolate_req_i) state_nxt = DRAIN;
            end
            DRAIN: begin
                if (!isolate_req_i)              state_nxt = RUN;
                else if (drained || drain_timeout) state_nxt = ISOLATED;
            end
            ISOLATED: begin
                if (!isolate_req_i) state_nxt = RUN;
            end
            default: state_nxt = RUN;
        endcase
    end

    assign isolate_o     = (state == ISOLATED);
    assign isolate_ack_o = (state == ISOLATED);

endmodule
